// File: rtl/led_pulse_stretch_pkg.sv
// led_pulse_stretch_pkg: shared state encodings and default 10 MHz blink timing
package led_pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int LED_ON_200MS  = 2000000;
    localparam int LED_OFF_100MS = 1000000;

endpackage

// File: rtl/led_pulse_stretch_cycle_timer.sv
// led_pulse_stretch_cycle_timer: clearable up-counter flagging equality with a terminal count
module led_pulse_stretch_cycle_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // count up every cycle; clr restarts the phase at zero
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else            cnt <= cnt + CNT_W'(1);
    end

    assign done = (cnt == tc);

endmodule

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: turns event strobes into queued, visible LED blinks (option: LED_STRETCH_RETRIGGER_EN)
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int ON_CYCLES  = LED_ON_200MS,
    parameter int OFF_CYCLES = LED_OFF_100MS,
    parameter int CNT_W      = 24,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tc;
    logic             done;
    logic             clr;
    logic             active;
    logic             retrig;
    logic             on_end;
    logic             gap_end;
    logic             inc;

    assign active = (state == ST_ON) || (state == ST_GAP);

`ifdef LED_STRETCH_RETRIGGER_EN
    assign retrig = pulse_in && (state == ST_ON);
`else
    assign retrig = 1'b0;
`endif

    // one timer serves both phases; the terminal count follows the current phase
    assign tc      = (state == ST_ON) ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1);
    assign on_end  = (state == ST_ON) && done && !retrig;
    assign gap_end = (state == ST_GAP) && done;
    assign clr     = !active || on_end || gap_end || retrig;
    assign inc     = pulse_in && active && !retrig;

    led_pulse_stretch_cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tc  (tc),
        .done(done)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // next state: a blink follows a gap when anything is queued or arriving now
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = pulse_in ? ST_ON : ST_IDLE;
            ST_ON:   state_nxt = on_end ? ST_GAP : ST_ON;
            ST_GAP:  state_nxt = !gap_end ? ST_GAP : ((pend != '0) || pulse_in) ? ST_ON : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // outputs decode the state register directly, so they change only on clock edges
    always_comb begin
        led_out = (state == ST_ON);
        busy    = (state != ST_IDLE);
    end

    // pending queue: at gap end one queued event is consumed while a new one may enter
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= overflow || (inc && !gap_end && (pend == PEND_MAX));
            pend     <= !active ? '0 :
                        gap_end ? ((pend != '0) ? pend - PEND_W'(1) + PEND_W'(inc) : '0) :
                        (inc && (pend != PEND_MAX)) ? pend + PEND_W'(1) : pend;
        end
    end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb_led_pulse_stretch: directed scoreboard bench for led_pulse_stretch (ON=4, OFF=2, PEND_W=2, CNT_W=3)
module tb_led_pulse_stretch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       led_out;
    logic       busy;
    logic       overflow;
    logic [1:0] pend;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .ON_CYCLES (4),
        .OFF_CYCLES(2),
        .CNT_W     (3),
        .PEND_W    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pend    (pend),
        .overflow(overflow)
    );

    // drive pulse_in=p for n edges; e = {led_out, busy, pend[1:0], overflow} expected after each edge
    task automatic run(input string tag, input int n, input logic p, input logic [4:0] e);
        logic [4:0] obs;
        logic [4:0] exp_v;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            pulse_in = p;
            @(posedge clk);
            #1;
            obs   = {led_out, busy, pend, overflow};
            exp_v = exp_q.pop_front();
            checks++;
            assert (obs === exp_v)
            else begin
                failures++;
                $error("FAIL %s cyc%0d led/busy/pend/ovf observed=%b expected=%b", tag, i, obs, exp_v);
            end
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run("reset", 3, 1'b1, 5'b00_00_0);
        rst = 1'b0;
        run("idle", 3, 1'b0, 5'b00_00_0);

        run("s1_start", 1, 1'b1, 5'b11_00_0);
        run("s1_on",    3, 1'b0, 5'b11_00_0);
        run("s1_gap",   2, 1'b0, 5'b01_00_0);
        run("s1_idle",  3, 1'b0, 5'b00_00_0);

        run("s2_p0",    1, 1'b1, 5'b11_00_0);
        run("s2_p1",    1, 1'b1, 5'b11_01_0);
        run("s2_p2",    1, 1'b1, 5'b11_10_0);
        run("s2_on1",   1, 1'b0, 5'b11_10_0);
        run("s2_gap1",  2, 1'b0, 5'b01_10_0);
        run("s2_on2",   4, 1'b0, 5'b11_01_0);
        run("s2_gap2",  2, 1'b0, 5'b01_01_0);
        run("s2_on3",   4, 1'b0, 5'b11_00_0);
        run("s2_gap3",  2, 1'b0, 5'b01_00_0);
        run("s2_idle",  2, 1'b0, 5'b00_00_0);

        run("s3_p0",    1, 1'b1, 5'b11_00_0);
        run("s3_p1",    1, 1'b1, 5'b11_01_0);
        run("s3_p2",    1, 1'b1, 5'b11_10_0);
        run("s3_p3",    1, 1'b1, 5'b11_11_0);
        run("s3_sat",   2, 1'b1, 5'b01_11_1);
        run("s3_on2",   4, 1'b0, 5'b11_10_1);
        run("s3_gap2",  2, 1'b0, 5'b01_10_1);
        run("s3_on3",   4, 1'b0, 5'b11_01_1);
        run("s3_gap3",  2, 1'b0, 5'b01_01_1);
        run("s3_on4",   4, 1'b0, 5'b11_00_1);
        run("s3_gap4",  2, 1'b0, 5'b01_00_1);
        run("s3_idle",  3, 1'b0, 5'b00_00_1);

        run("s5_p0",    1, 1'b1, 5'b11_00_1);
        run("s5_p1",    1, 1'b1, 5'b11_01_1);
        rst = 1'b1;
        run("s5_rst",   1, 1'b1, 5'b00_00_0);
        rst = 1'b0;
        run("s5_after", 8, 1'b0, 5'b00_00_0);

        run("s4_p0",    1, 1'b1, 5'b11_00_0);
        run("s4_p1",    1, 1'b1, 5'b11_01_0);
        run("s4_on1",   2, 1'b0, 5'b11_01_0);
        run("s4_gap1",  2, 1'b0, 5'b01_01_0);
        run("s4_incdec",1, 1'b1, 5'b11_01_0);
        run("s4_on2",   3, 1'b0, 5'b11_01_0);
        run("s4_gap2",  2, 1'b0, 5'b01_01_0);
        run("s4_on3",   4, 1'b0, 5'b11_00_0);
        run("s4_gap3",  2, 1'b0, 5'b01_00_0);
        run("s4_idle",  2, 1'b0, 5'b00_00_0);

        run("s4b_p0",   1, 1'b1, 5'b11_00_0);
        run("s4b_on1",  3, 1'b0, 5'b11_00_0);
        run("s4b_gap1", 2, 1'b0, 5'b01_00_0);
        run("s4b_late", 1, 1'b1, 5'b11_00_0);
        run("s4b_on2",  3, 1'b0, 5'b11_00_0);
        run("s4b_gap2", 2, 1'b0, 5'b01_00_0);
        run("s4b_idle", 2, 1'b0, 5'b00_00_0);

`ifdef LED_STRETCH_RETRIGGER_EN
        run("rt_p0",    1, 1'b1, 5'b11_00_0);
        run("rt_on",    1, 1'b0, 5'b11_00_0);
        run("rt_retrig",1, 1'b1, 5'b11_00_0);
        run("rt_ext",   3, 1'b0, 5'b11_00_0);
        run("rt_gap",   2, 1'b0, 5'b01_00_0);
        run("rt_idle",  2, 1'b0, 5'b00_00_0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
